// File: rtl/eth_tx_pkg.sv
// Shared transmit-path definitions: Ethernet payload bounds and the loader FSM state type.
package eth_tx_pkg;

    localparam int MIN_PAYLOAD = 46;
    localparam int MAX_PAYLOAD = 1500;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DROP,
        PAD,
        DONE
    } loader_state_t;

endpackage

// File: rtl/pkt_credit_cnt.sv
// Counts packets handed downstream but not yet consumed; flags when the outstanding limit is hit.
module pkt_credit_cnt #(
    parameter int LIMIT = 2,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_limit
);

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    assign w_at_limit = (r_count >= CW'(LIMIT));

    // Simultaneous inc and dec cancel; a dec with nothing outstanding is ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_limit = w_at_limit;

endmodule

// File: rtl/tx_payload_loader.sv
// Transmit write-side front end: streams payload bytes into the async FIFO, pads/truncates
// to Ethernet payload bounds, and throttles intake on the number of un-transmitted packets.
module tx_payload_loader #(
    parameter int WIDTH       = 8,
    parameter int MIN_PAYLOAD = eth_tx_pkg::MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = eth_tx_pkg::MAX_PAYLOAD,
    parameter int MAX_PENDING = 2,
    parameter int LEN_W       = 11
) (
    input  logic                             sys_clk,
    input  logic                             eth_rst,
    input  logic [WIDTH-1:0]                 s_data,
    input  logic                             s_valid,
    input  logic                             s_last,
    output logic                             s_ready,
    input  logic                             fifo_full,
    output logic                             fifo_w_en,
    output logic [WIDTH-1:0]                 fifo_data,
    input  logic                             pct_txed,
    output logic                             pct_qued,
    output logic [LEN_W-1:0]                 pct_len,
    output logic                             pct_trunc,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending
);

    import eth_tx_pkg::*;

    localparam int PW = $clog2(MAX_PENDING + 1);

    loader_state_t r_state;
    loader_state_t w_next;

    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_pct_len;
    logic             r_trunc;
    logic             r_ready_en;

    logic [LEN_W-1:0] w_cnt_new;
    logic             w_ready;
    logic             w_byte_wr;
    logic             w_pad_wr;
    logic             w_cnt_load;
    logic             w_cnt_step;
    logic             w_set_trunc;
    logic             w_done;
    logic             w_limit;
    logic [PW-1:0]    w_pending;

    assign w_cnt_new = (r_state == IDLE) ? LEN_W'(1) : (r_cnt + 1'b1);
    assign w_done    = (r_state == DONE);

    always_ff @(posedge sys_clk) begin
        if (eth_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_byte_wr   = 1'b0;
        w_pad_wr    = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_step  = 1'b0;
        w_set_trunc = 1'b0;
        case (r_state)
            IDLE, LOAD: begin
                // A new packet additionally waits for a free credit and the post-reset cycle.
                if (r_state == IDLE) begin
                    w_ready = r_ready_en & ~fifo_full & ~w_limit;
                end else begin
                    w_ready = ~fifo_full;
                end
                if (s_valid && w_ready) begin
                    w_byte_wr  = 1'b1;
                    w_cnt_load = (r_state == IDLE);
                    w_cnt_step = (r_state == LOAD);
                    if (s_last) begin
                        w_next = (w_cnt_new < LEN_W'(MIN_PAYLOAD)) ? PAD : DONE;
                    end else if (w_cnt_new == LEN_W'(MAX_PAYLOAD)) begin
                        w_next      = DROP;
                        w_set_trunc = 1'b1;
                    end else begin
                        w_next = LOAD;
                    end
                end
            end
            DROP: begin
                w_ready = 1'b1;
                if (s_valid && s_last) begin
                    w_next = DONE;
                end
            end
            PAD: begin
                if (!fifo_full) begin
                    w_pad_wr   = 1'b1;
                    w_cnt_step = 1'b1;
                    if (w_cnt_new == LEN_W'(MIN_PAYLOAD)) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (eth_rst) begin
            r_cnt      <= '0;
            r_trunc    <= 1'b0;
            r_pct_len  <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_cnt_load || w_cnt_step) begin
                r_cnt <= w_cnt_new;
            end
            if (w_set_trunc) begin
                r_trunc <= 1'b1;
            end else if (w_done) begin
                r_trunc <= 1'b0;
            end
            if (w_done) begin
                r_pct_len <= r_cnt;
            end
        end
    end

    pkt_credit_cnt #(
        .LIMIT (MAX_PENDING),
        .CW    (PW)
    ) u_credit (
        .i_clk   (sys_clk),
        .i_rst   (eth_rst),
        .i_inc   (w_done),
        .i_dec   (pct_txed),
        .o_count (w_pending),
        .o_limit (w_limit)
    );

    // The write strobe and data follow the handshake directly, with no register stage.
    assign s_ready   = w_ready;
    assign fifo_w_en = w_byte_wr | w_pad_wr;
    assign fifo_data = w_byte_wr ? s_data : '0;
    assign pct_qued  = w_done;
    assign pct_len   = w_done ? r_cnt : r_pct_len;
    assign pct_trunc = w_done & r_trunc;
    assign pending   = w_pending;

endmodule

// File: tb/tb_tx_payload_loader.sv
// Scoreboard bench for tx_payload_loader: expected FIFO writes and packet reports are derived
// from payload length rules and checked by an independent monitor.
module tb_tx_payload_loader;

    localparam int MIN_P    = 46;
    localparam int MAX_P    = 1500;
    localparam int MAX_PEND = 2;
    localparam int PW       = 2;

    typedef struct packed {
        logic [15:0] len;
        logic        trunc;
    } pkt_t;

    logic        sys_clk   = 1'b0;
    logic        eth_rst   = 1'b1;
    logic [7:0]  s_data    = 8'h00;
    logic        s_valid   = 1'b0;
    logic        s_last    = 1'b0;
    logic        s_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_w_en;
    logic [7:0]  fifo_data;
    logic        pct_txed  = 1'b0;
    logic        pct_qued;
    logic [10:0] pct_len;
    logic        pct_trunc;
    logic [PW-1:0] pending;

    logic [7:0] exp_wr[$];
    pkt_t       exp_pkt[$];

    int checks      = 0;
    int errors      = 0;
    int mcyc        = 0;
    int last_wr     = 0;
    int first_wr    = 0;
    int last_span   = 0;
    int qued_cnt    = 0;
    int exp_pending = 0;
    int txed_req    = 0;
    int txed_done   = 0;
    int nq          = 0;
    int w1          = -100;
    int w2          = -100;
    bit in_pkt      = 0;
    bit pend_chk    = 0;
    bit post_rst    = 0;
    bit txed_rand   = 0;
    bit txed_coinc  = 0;
    bit full_rand   = 0;
    logic [7:0] e_byte;
    pkt_t       e_pkt;

    tx_payload_loader #(
        .WIDTH       (8),
        .MIN_PAYLOAD (MIN_P),
        .MAX_PAYLOAD (MAX_P),
        .MAX_PENDING (MAX_PEND),
        .LEN_W       (11)
    ) dut (
        .sys_clk   (sys_clk),
        .eth_rst   (eth_rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .fifo_full (fifo_full),
        .fifo_w_en (fifo_w_en),
        .fifo_data (fifo_data),
        .pct_txed  (pct_txed),
        .pct_qued  (pct_qued),
        .pct_len   (pct_len),
        .pct_trunc (pct_trunc),
        .pending   (pending)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // FIFO backpressure: random, or two scheduled 5-cycle windows.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (full_rand) fifo_full = ($urandom % 4 == 0);
            else fifo_full = (mcyc >= w1 && mcyc < w1 + 5) || (mcyc >= w2 && mcyc < w2 + 5);
        end
    end

    // Monitor: compares every write and packet report with the scoreboard, tracks the
    // outstanding-packet count, and drives pct_txed for the following clock edge.
    initial begin
        forever begin
            @(negedge sys_clk);
            mcyc++;
            if (eth_rst) begin
                exp_wr.delete();
                exp_pkt.delete();
                exp_pending = 0;
                post_rst    = 1;
                in_pkt      = 0;
                pend_chk    = 0;
                pct_txed    = 1'b0;
            end else begin
                if (post_rst) begin
                    checkOutput("rst_s_ready", s_ready, 0);
                    checkOutput("rst_fifo_w_en", fifo_w_en, 0);
                    checkOutput("rst_fifo_data", fifo_data, 0);
                    checkOutput("rst_pct_qued", pct_qued, 0);
                    checkOutput("rst_pct_len", pct_len, 0);
                    checkOutput("rst_pct_trunc", pct_trunc, 0);
                    checkOutput("rst_pending", pending, 0);
                    post_rst = 0;
                end
                if (fifo_w_en) begin
                    checkOutput("wr_while_full", fifo_full, 0);
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_write: got data %0d, expected no write", fifo_data);
                    end else begin
                        e_byte = exp_wr.pop_front();
                        checkOutput("fifo_data", fifo_data, e_byte);
                    end
                    if (!in_pkt) begin
                        first_wr = mcyc;
                        in_pkt   = 1;
                    end
                    last_wr = mcyc;
                end
                if (pct_qued) begin
                    checkOutput("done_s_ready", s_ready, 0);
                    if (exp_pkt.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_qued: got pct_qued len %0d, expected none", pct_len);
                    end else begin
                        e_pkt = exp_pkt.pop_front();
                        checkOutput("pct_len", pct_len, int'(e_pkt.len));
                        checkOutput("pct_trunc", pct_trunc, e_pkt.trunc);
                        if (!e_pkt.trunc) checkOutput("qued_latency", mcyc - last_wr, 1);
                    end
                    last_span = last_wr - first_wr + 1;
                    in_pkt    = 0;
                    qued_cnt++;
                end
                if (pend_chk) checkOutput("pending", pending, exp_pending);
                if (txed_rand) begin
                    pct_txed = ($urandom % 6 == 0);
                end else if (txed_coinc && pct_qued) begin
                    pct_txed = 1'b1;
                end else if (txed_done != txed_req) begin
                    pct_txed = 1'b1;
                    txed_done++;
                end else begin
                    pct_txed = 1'b0;
                end
                if (pct_qued && !pct_txed) exp_pending++;
                else if (pct_txed && !pct_qued && exp_pending > 0) exp_pending--;
                pend_chk = pct_qued || pct_txed;
            end
        end
    end

    // Push the expected FIFO image of a payload, then drive it byte by byte.
    task automatic applyStimulus(input int n, input int abort_at, input bit seq, input bit gaps);
        logic [7:0] d[];
        int kept;
        bit got;
        d = new[n];
        for (int i = 0; i < n; i++) d[i] = seq ? 8'(i) : 8'($urandom);
        kept = (n > MAX_P) ? MAX_P : n;
        for (int i = 0; i < kept; i++) exp_wr.push_back(d[i]);
        for (int i = kept; i < MIN_P; i++) exp_wr.push_back(8'h00);
        exp_pkt.push_back('{len: 16'((kept < MIN_P) ? MIN_P : kept), trunc: (n > MAX_P)});
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_data  = 8'h00;
                eth_rst = 1'b1;
                @(posedge sys_clk);
                #1;
                eth_rst = 1'b0;
                return;
            end
            if (gaps && ($urandom % 5 == 0)) begin
                s_valid = 1'b0;
                @(posedge sys_clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = d[i];
            s_last  = (i == n - 1);
            got = 0;
            for (int t = 0; t < 20000 && !got; t++) begin
                @(negedge sys_clk);
                got = s_ready;
                @(posedge sys_clk);
                #1;
            end
            if (!got) begin
                checkOutput("accept_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitQued(input int target);
        for (int t = 0; t < 5000 && qued_cnt < target; t++) begin
            @(posedge sys_clk);
            #1;
        end
        checkOutput("qued_count", qued_cnt, target);
    endtask

    task automatic drainPending();
        txed_req = txed_req + exp_pending;
        for (int t = 0; t < 100 && txed_done != txed_req; t++) begin
            @(posedge sys_clk);
            #1;
        end
        @(posedge sys_clk);
        #1;
        checkOutput("drain_pending", pending, 0);
    endtask

    initial begin
        #900000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected run to complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int n, r, cur;
        repeat (3) @(posedge sys_clk);
        #1;
        eth_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        applyStimulus(60, -1, 1, 0);
        nq++;
        waitQued(nq);
        checkOutput("span_60", last_span, 60);
        @(negedge sys_clk);
        checkOutput("pending_after_60", pending, 1);
        @(posedge sys_clk);
        #1;
        drainPending();

        applyStimulus(10, -1, 1, 0);
        nq++;
        waitQued(nq);
        checkOutput("span_pad_10", last_span, 46);
        drainPending();

        applyStimulus(1600, -1, 0, 0);
        nq++;
        waitQued(nq);
        @(negedge sys_clk);
        checkOutput("len_held_trunc", pct_len, 1500);
        @(posedge sys_clk);
        #1;
        drainPending();

        applyStimulus(1500, -1, 0, 0);
        nq++;
        waitQued(nq);
        drainPending();

        cur = mcyc;
        w1  = cur + 12;
        w2  = cur + 42;
        fork
            applyStimulus(30, -1, 1, 0);
            begin
                for (int k = 0; k < 75; k++) begin
                    @(negedge sys_clk);
                    if (fifo_full) checkOutput("stall_s_ready", s_ready, 0);
                end
            end
        join
        @(posedge sys_clk);
        #1;
        w1 = -100;
        w2 = -100;
        nq++;
        waitQued(nq);
        drainPending();

        applyStimulus(10, -1, 0, 0);
        nq++;
        applyStimulus(10, -1, 0, 0);
        nq++;
        waitQued(nq);
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            checkOutput("limit_s_ready", s_ready, 0);
            checkOutput("limit_pending", pending, 2);
        end
        @(posedge sys_clk);
        #1;
        txed_req++;
        @(negedge sys_clk);
        @(negedge sys_clk);
        checkOutput("txed_s_ready", s_ready, 1);
        checkOutput("txed_pending", pending, 1);
        @(posedge sys_clk);
        #1;
        txed_coinc = 1;
        applyStimulus(12, -1, 0, 0);
        nq++;
        waitQued(nq);
        txed_coinc = 0;
        @(negedge sys_clk);
        checkOutput("coinc_pending", pending, 1);
        @(posedge sys_clk);
        #1;
        drainPending();

        applyStimulus(100, 20, 1, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        applyStimulus(50, -1, 1, 0);
        nq++;
        waitQued(nq);
        drainPending();

        full_rand = 1;
        txed_rand = 1;
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom % 10);
            if (r < 7) n = 1 + int'($urandom % 80);
            else if (r < 9) n = 40 + int'($urandom % 11);
            else n = 1498 + int'($urandom % 5);
            applyStimulus(n, -1, 0, 1);
            nq++;
        end
        full_rand = 0;
        waitQued(nq);
        txed_rand = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        drainPending();
        checkOutput("exp_wr_empty", exp_wr.size(), 0);
        checkOutput("exp_pkt_empty", exp_pkt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
